// File: rtl/fetch_sequencer_pkg.sv
// Shared pipeline definitions for the fetch stage: sequencer state encodings
// and default widths/lengths used by the fetch sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_PC_W         = 8;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;
  localparam int unsigned FCNT_W           = 3;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC and arbitrates advance / hold / redirect /
// halt, producing the imem address, a fetch qualifier and a wrong-path flush.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W         = DEF_PC_W,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_req,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_offset,
  input  logic             halt_req,
  input  logic             start,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output seq_state_e       fsm_state
);

  seq_state_e        state;
  logic [FCNT_W-1:0] fcnt;

  assign fetch_valid = !reset && (state != ST_HALT) && !stall_req;
  assign flush       = (state == ST_FLUSH);
  assign halted      = (state == ST_HALT);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_W'(RESET_PC);
      state       <= ST_RUN;
      fcnt        <= '0;
      fetch_count <= '0;
    end else begin
      if (fetch_valid) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
      case (state)
        ST_RUN: begin
          // A resolved branch outranks halt and stall: it is the older instruction.
          if (br_taken) begin
            pc    <= pc + br_offset;
            state <= ST_FLUSH;
            fcnt  <= FCNT_W'(FLUSH_CYCLES);
          end else if (halt_req) begin
            state <= ST_HALT;
          end else if (!stall_req) begin
            pc <= pc + PC_W'(1);
          end
        end
        ST_FLUSH: begin
          // Branch/halt requests here come from wrong-path instructions.
          fcnt <= fcnt - FCNT_W'(1);
          if (!stall_req) begin
            pc <= pc + PC_W'(1);
          end
          if (fcnt == FCNT_W'(1)) begin
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (start) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// run, all compared against a behavioural model of the sequencing rules.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int FLUSH_N = 2;

  logic             clk;
  logic             reset;
  logic             stall_req;
  logic             br_taken;
  logic [PC_W-1:0]  br_offset;
  logic             halt_req;
  logic             start;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;
  seq_state_e       fsm_state;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [PC_W-1:0]  m_pc;
  int               m_flush_left;
  bit               m_halted;
  logic [CNT_W-1:0] m_count;
  bit               obs_fv;
  bit               exp_fv;

  fetch_sequencer #(
    .PC_W(PC_W), .RESET_PC(0), .FLUSH_CYCLES(FLUSH_N), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .br_taken(br_taken),
    .br_offset(br_offset), .halt_req(halt_req), .start(start), .pc(pc),
    .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
    .fetch_count(fetch_count), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, capture fetch_valid mid-cycle, advance the
  // model across the edge, and return 1 time unit after that edge.
  task automatic drive_cycle(input bit rst, input bit stl, input bit br,
                             input logic [PC_W-1:0] off, input bit hlt, input bit st);
    @(negedge clk);
    reset = rst; stall_req = stl; br_taken = br; br_offset = off;
    halt_req = hlt; start = st;
    #1;
    obs_fv = fetch_valid;
    exp_fv = !rst && !m_halted && !stl;
    if (rst) begin
      m_pc = '0; m_flush_left = 0; m_halted = 0; m_count = '0;
    end else begin
      if (exp_fv) m_count = m_count + 1;
      if (m_halted) begin
        if (st) m_halted = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left = m_flush_left - 1;
        if (!stl) m_pc = m_pc + 1;
      end else if (br) begin
        m_pc = m_pc + off;
        m_flush_left = FLUSH_N;
      end else if (hlt) begin
        m_halted = 1;
      end else if (!stl) begin
        m_pc = m_pc + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(0, 0, 0, '0, 0, 0);
  endtask

  // Redirect to an absolute address, holding it through the flush window.
  task automatic goto(input logic [PC_W-1:0] target);
    drive_cycle(0, 0, 1, target - m_pc, 0, 0);
    for (int i = 0; i < FLUSH_N; i++) drive_cycle(0, 1, 0, '0, 0, 0);
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, 0, '0, 0, 0);
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", pc); end
    total++; if (flush !== 1'b0 || halted !== 1'b0) begin bad++;
      $display("FAIL reset_flags got flush=%b halted=%b exp 0 0", flush, halted); end
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    total++; if (fsm_state !== ST_RUN) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    for (int i = 1; i <= 5; i++) begin
      idle();
      total++; if (pc !== PC_W'(i) || obs_fv !== 1'b1 || flush !== 1'b0) begin bad++;
        $display("FAIL idle_seq got pc=%h fv=%b flush=%b exp pc=%h fv=1 flush=0", pc, obs_fv, flush, i[7:0]); end
    end
    total++; if (fetch_count !== 16'd5) begin bad++; $display("FAIL idle_count got=%0d exp=5", fetch_count); end
  endtask

  task automatic test_branch_back_to_back();
    goto(8'h10);
    total++; if (pc !== 8'h10 || flush !== 1'b0) begin bad++;
      $display("FAIL goto_10 got pc=%h flush=%b exp 10 0", pc, flush); end
    drive_cycle(0, 0, 1, 8'hFC, 0, 0);
    total++; if (pc !== 8'h0C || flush !== 1'b1) begin bad++;
      $display("FAIL br_back got pc=%h flush=%b exp 0c 1", pc, flush); end
    drive_cycle(0, 0, 1, PC_W'($urandom_range(1, 255)), 0, 0);
    total++; if (pc !== 8'h0D || flush !== 1'b1) begin bad++;
      $display("FAIL br_in_flush got pc=%h flush=%b exp 0d 1", pc, flush); end
    idle();
    total++; if (pc !== 8'h0E || flush !== 1'b0 || pc !== m_pc) begin bad++;
      $display("FAIL flush_end got pc=%h flush=%b exp 0e 0", pc, flush); end
  endtask

  task automatic test_wrap();
    goto(8'hFE);
    idle();
    total++; if (pc !== 8'hFF) begin bad++; $display("FAIL wrap1 got=%h exp=ff", pc); end
    idle();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL wrap2 got=%h exp=00", pc); end
    idle();
    total++; if (pc !== 8'h01) begin bad++; $display("FAIL wrap3 got=%h exp=01", pc); end
    goto(8'hFD);
    drive_cycle(0, 0, 1, 8'h05, 0, 0);
    total++; if (pc !== 8'h02) begin bad++; $display("FAIL br_wrap got=%h exp=02", pc); end
    for (int i = 0; i < FLUSH_N; i++) idle();
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] cnt0;
    goto(8'h20);
    cnt0 = m_count;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, 0, '0, 0, 0);
      total++; if (pc !== 8'h20 || obs_fv !== 1'b0 || fetch_count !== cnt0) begin bad++;
        $display("FAIL stall_hold got pc=%h fv=%b cnt=%0d exp 20 0 %0d", pc, obs_fv, fetch_count, cnt0); end
    end
    idle();
    total++; if (pc !== 8'h21 || fetch_count !== cnt0 + 1) begin bad++;
      $display("FAIL stall_resume got pc=%h cnt=%0d exp 21 %0d", pc, fetch_count, cnt0 + 1); end
  endtask

  task automatic test_halt();
    goto(8'h30);
    drive_cycle(0, 0, 0, '0, 1, 0);
    total++; if (halted !== 1'b1 || pc !== 8'h30) begin bad++;
      $display("FAIL halt_enter got halted=%b pc=%h exp 1 30", halted, pc); end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, $urandom_range(0, 1), 1, PC_W'($urandom_range(1, 255)), 1, 0);
      total++; if (halted !== 1'b1 || pc !== 8'h30 || obs_fv !== 1'b0 || flush !== 1'b0) begin bad++;
        $display("FAIL halt_frozen got halted=%b pc=%h fv=%b flush=%b exp 1 30 0 0", halted, pc, obs_fv, flush); end
    end
    drive_cycle(0, 0, 0, '0, 0, 1);
    total++; if (halted !== 1'b0 || pc !== 8'h30) begin bad++;
      $display("FAIL halt_exit got halted=%b pc=%h exp 0 30", halted, pc); end
    idle();
    total++; if (pc !== 8'h31) begin bad++; $display("FAIL halt_resume got=%h exp=31", pc); end
  endtask

  task automatic test_br_with_halt();
    goto(8'h40);
    drive_cycle(0, 1, 1, 8'h08, 1, 0);
    total++; if (pc !== 8'h48 || flush !== 1'b1 || halted !== 1'b0) begin bad++;
      $display("FAIL br_halt got pc=%h flush=%b halted=%b exp 48 1 0", pc, flush, halted); end
    drive_cycle(0, 0, 0, '0, 1, 0);
    idle();
    total++; if (halted !== 1'b0 || flush !== 1'b0 || pc !== 8'h4A) begin bad++;
      $display("FAIL halt_in_flush got halted=%b flush=%b pc=%h exp 0 0 4a", halted, flush, pc); end
  endtask

  task automatic test_reset_mid();
    goto(8'h55);
    drive_cycle(0, 0, 1, 8'h10, 0, 0);
    idle();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL pre_reset_flush got=%b exp=1", flush); end
    drive_cycle(1, 0, 1, 8'h10, 1, 1);
    total++; if (pc !== 8'h00 || flush !== 1'b0 || fetch_count !== 16'd0 || fsm_state !== ST_RUN) begin bad++;
      $display("FAIL reset_in_flush got pc=%h flush=%b cnt=%0d st=%0d exp 00 0 0 0", pc, flush, fetch_count, fsm_state); end
    goto(8'h66);
    drive_cycle(0, 0, 0, '0, 1, 0);
    drive_cycle(1, 0, 0, '0, 0, 0);
    total++; if (pc !== 8'h00 || halted !== 1'b0 || fetch_count !== 16'd0 || fsm_state !== ST_RUN) begin bad++;
      $display("FAIL reset_in_halt got pc=%h halted=%b cnt=%0d st=%0d exp 00 0 0 0", pc, halted, fetch_count, fsm_state); end
  endtask

  task automatic test_random();
    seq_state_e exp_st;
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0, PC_W'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      exp_st = m_halted ? ST_HALT : (m_flush_left > 0 ? ST_FLUSH : ST_RUN);
      total++;
      if (pc !== m_pc || obs_fv !== exp_fv || flush !== (m_flush_left > 0) ||
          halted !== m_halted || fetch_count !== m_count || fsm_state !== exp_st) begin
        bad++;
        $display("FAIL random cyc=%0d got pc=%h fv=%b fl=%b h=%b cnt=%0d st=%0d exp pc=%h fv=%b fl=%b h=%b cnt=%0d st=%0d",
                 i, pc, obs_fv, flush, halted, fetch_count, fsm_state,
                 m_pc, exp_fv, m_flush_left > 0, m_halted, m_count, exp_st);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall_req = 1'b0; br_taken = 1'b0; br_offset = '0;
    halt_req = 1'b0; start = 1'b0;
    m_pc = '0; m_flush_left = 0; m_halted = 0; m_count = '0;
    test_reset();
    test_branch_back_to_back();
    test_wrap();
    test_stall();
    test_halt();
    test_br_with_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
